// File: rtl/display_row_streamer.sv
// Captures evaluated display frames into a two-slot ping-pong buffer and
// streams each frame to the display driver one row per valid/ready handshake.
module display_row_streamer #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 8,
    parameter int CNT_W  = 16,
    localparam int IDX_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int FRAME_W = WIDTH * HEIGHT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [WIDTH-1:0]   row_data,
    output logic [IDX_W-1:0]   row_idx,
    output logic               row_first,
    output logic               row_last,
    output logic               row_valid,
    input  logic               row_ready,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               busy
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             state;
    logic [FRAME_W-1:0] frame_buf [2];
    logic [1:0]         occ;
    logic               wptr;
    logic               rptr;

    logic               acc;
    logic               xfer;
    logic               done;
    logic [1:0]         occ_nx;
    logic               nf_idx;
    logic [FRAME_W-1:0] next_frame;

    function automatic logic [WIDTH-1:0] row_of(input logic [FRAME_W-1:0] f, input int r);
        return f[r*WIDTH +: WIDTH];
    endfunction

    always_comb begin
        acc    = pix_valid && pix_ready;
        xfer   = row_valid && row_ready;
        done   = xfer && (row_idx == IDX_W'(HEIGHT - 1));
        occ_nx = occ + {1'b0, acc} - {1'b0, done};
        nf_idx = rptr ^ done;
        // A frame being written on this same edge is not in the buffer yet,
        // so the first row of the next frame is taken straight from pix_in.
        if (acc && (wptr == nf_idx))
            next_frame = pix_in;
        else
            next_frame = frame_buf[nf_idx];
    end

    always_ff @(posedge clk) begin
        if (acc)
            frame_buf[wptr] <= pix_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            occ       <= 2'd0;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
            pix_ready <= 1'b1;
            busy      <= 1'b0;
            row_valid <= 1'b0;
            row_data  <= '0;
            row_idx   <= '0;
            row_first <= 1'b0;
            row_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (acc)
                wptr <= ~wptr;
            occ       <= occ_nx;
            pix_ready <= (occ_nx != 2'd2);
            busy      <= (occ_nx != 2'd0);

            case (state)
                IDLE: begin
                    if (occ != 2'd0 || acc) begin
                        state     <= STREAM;
                        row_valid <= 1'b1;
                        row_idx   <= '0;
                        row_data  <= row_of(next_frame, 0);
                        row_first <= 1'b1;
                        row_last  <= (HEIGHT == 1);
                    end
                end
                STREAM: begin
                    if (done) begin
                        rptr      <= ~rptr;
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        row_idx   <= '0;
                        if (occ_nx != 2'd0) begin
                            row_data  <= row_of(next_frame, 0);
                            row_first <= 1'b1;
                            row_last  <= (HEIGHT == 1);
                        end else begin
                            state     <= IDLE;
                            row_valid <= 1'b0;
                            row_first <= 1'b0;
                            row_last  <= 1'b0;
                        end
                    end else if (xfer) begin
                        row_idx   <= row_idx + IDX_W'(1);
                        row_data  <= row_of(frame_buf[rptr], int'(row_idx) + 1);
                        row_first <= 1'b0;
                        row_last  <= (int'(row_idx) + 1 == HEIGHT - 1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
